cordic_engine: RTL and testbench

- Parametrised iterative CORDIC core: one micro-rotation per clock, configurable data/angle width and iteration count.
- Supports rotation mode (rotate (x,y) by z) and vectoring mode (magnitude/atan2), both with full-circle range via quadrant pre-fold.
- Valid/ready handshake on both sides.
- Feeds the DSP mixers / phase detectors; one transaction in flight at a time.

---
 rtl/cordic_engine.sv | 295 +++++++++++++++++++++++++++++
 tb/tb_cordic_engine.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_engine.sv
// ---------------------------------------------------------------------------
// cordic_engine
//
// Iterative CORDIC core that performs one micro-rotation per clock.
//
// Modes (latched when a transaction is accepted):
//   - Rotation (mode=0): rotates (x,y) by the angle z.
//   - Vectoring (mode=1): drives y to zero. This gives the magnitude on x
//     and z_in + atan2(y,x) on z.
// A quadrant pre-fold on load extends both modes to the full circle.
// Only one transaction is in flight at a time.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   in_valid/in_ready   input handshake. mode, x_in, y_in and z_in are
//                       sampled on the accept edge only.
//   x_in, y_in          signed W-bit vector
//   z_in                signed AW-bit angle, Q3.(AW-3) radians
//   out_valid/out_ready output handshake. The result is held while stalled.
//   x_out, y_out        signed W+2-bit results, including the CORDIC gain
//   z_out               residual angle (rotation) or accumulated angle
//                       (vectoring)
//   busy                high while iterating or holding a result
// ---------------------------------------------------------------------------
module cordic_engine #(
  parameter int W     = 16,
  parameter int AW    = 16,
  parameter int ITER  = 14,
  parameter int GUARD = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 mode,
  input  logic signed [W-1:0]  x_in,
  input  logic signed [W-1:0]  y_in,
  input  logic signed [AW-1:0] z_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [W+1:0]  x_out,
  output logic signed [W+1:0]  y_out,
  output logic signed [AW-1:0] z_out,
  output logic                 busy
);

  // Internal x/y width: two growth bits for the CORDIC gain, plus guard LSBs.
  localparam int IW = W + 2 + GUARD;
  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  // pi/2 in the angle format, rounded to nearest.
  localparam real HALF_PI_R = 1.5707963267948966 * (2.0 ** (AW - 3));
  localparam logic signed [AW-1:0] HALF_PI = AW'($rtoi(HALF_PI_R + 0.5));

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // Arctangent table: round(atan(2^-i) * 2^29).
  // It is rescaled below to the configured angle width.
  // -------------------------------------------------------------------------
  function automatic logic [31:0] atan_t(input int i);
    logic [31:0] t;
    case (i)
      0:       t = 32'd421657428;
      1:       t = 32'd248918915;
      2:       t = 32'd131521918;
      3:       t = 32'd66762579;
      4:       t = 32'd33510843;
      5:       t = 32'd16771758;
      6:       t = 32'd8387925;
      7:       t = 32'd4194219;
      8:       t = 32'd2097141;
      9:       t = 32'd1048575;
      10:      t = 32'd524288;
      11:      t = 32'd262144;
      12:      t = 32'd131072;
      13:      t = 32'd65536;
      14:      t = 32'd32768;
      15:      t = 32'd16384;
      16:      t = 32'd8192;
      17:      t = 32'd4096;
      18:      t = 32'd2048;
      19:      t = 32'd1024;
      20:      t = 32'd512;
      21:      t = 32'd256;
      22:      t = 32'd128;
      23:      t = 32'd64;
      default: t = 32'd0;
    endcase
    return t;
  endfunction

  // The table is stored at 2^29 scale, which is Q3.29 for a 32-bit angle.
  // Narrower angles take a round-half-up right shift.
  logic signed [AW-1:0] angle_tab [ITER];

  for (genvar gi = 0; gi < ITER; gi++) begin : g_angle
    if (AW >= 32) begin : g_full
      assign angle_tab[gi] = AW'(atan_t(gi));
    end else begin : g_round
      assign angle_tab[gi] = AW'((atan_t(gi) + (32'd1 << (31 - AW))) >> (32 - AW));
    end
  end

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 mode_q, mode_d;
  logic signed [IW-1:0] x_q, x_d, y_q, y_d;
  logic signed [AW-1:0] z_q, z_d;
  logic signed [W+1:0]  x_out_q, x_out_d, y_out_q, y_out_d;
  logic signed [AW-1:0] z_out_q, z_out_d;

  logic accept;
  logic last_step;

  assign accept    = in_valid && in_ready;
  assign last_step = (state_q == S_ITER) && (cnt_q == CW'(ITER - 1));

  // -------------------------------------------------------------------------
  // Load path: widen the inputs, then fold into the convergence range.
  // The iteration only converges for about +/-1.74 rad, so a +/-pi/2
  // pre-rotation brings any start angle or vector inside that range.
  // -------------------------------------------------------------------------
  logic signed [IW-1:0] x_ext, y_ext, x_fold, y_fold;
  logic signed [AW-1:0] z_fold;

  always_comb begin
    x_ext  = IW'(x_in) <<< GUARD;
    y_ext  = IW'(y_in) <<< GUARD;
    x_fold = x_ext;
    y_fold = y_ext;
    z_fold = z_in;
    if (!mode) begin
      if (z_in > HALF_PI) begin
        x_fold = -y_ext;
        y_fold = x_ext;
        z_fold = z_in - HALF_PI;
      end else if (z_in < -HALF_PI) begin
        x_fold = y_ext;
        y_fold = -x_ext;
        z_fold = z_in + HALF_PI;
      end
    end else if (x_in[W-1]) begin
      // Left half-plane: rotate by -/+pi/2 into the right half-plane.
      // Pre-load the accumulated angle with the matching +/-pi/2.
      if (!y_in[W-1]) begin
        x_fold = y_ext;
        y_fold = -x_ext;
        z_fold = z_in + HALF_PI;
      end else begin
        x_fold = -y_ext;
        y_fold = x_ext;
        z_fold = z_in - HALF_PI;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Micro-rotation i = cnt_q, computed from the current register values.
  // The "ccw" direction subtracts y from x and the table angle from z.
  // -------------------------------------------------------------------------
  logic signed [IW-1:0] x_sh, y_sh, x_rot, y_rot;
  logic signed [AW-1:0] z_rot;
  logic                 step_ccw;

  always_comb begin
    x_sh     = x_q >>> cnt_q;
    y_sh     = y_q >>> cnt_q;
    step_ccw = mode_q ? y_q[IW-1] : ~z_q[AW-1];
    if (step_ccw) begin
      x_rot = x_q - y_sh;
      y_rot = y_q + x_sh;
      z_rot = z_q - angle_tab[cnt_q];
    end else begin
      x_rot = x_q + y_sh;
      y_rot = y_q - x_sh;
      z_rot = z_q + angle_tab[cnt_q];
    end
  end

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        if (cnt_q == CW'(ITER - 1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // A new input accepted in the same cycle avoids a bubble.
        if (out_ready) begin
          state_d = in_valid ? S_ITER : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    in_ready  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready);
    out_valid = (state_q == S_DONE);
    busy      = (state_q == S_ITER) || (state_q == S_DONE);
  end

  // -------------------------------------------------------------------------
  // Datapath next-state
  // -------------------------------------------------------------------------
  always_comb begin
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    x_out_d = x_out_q;
    y_out_d = y_out_q;
    z_out_d = z_out_q;

    if (accept) begin
      cnt_d  = '0;
      mode_d = mode;
      x_d    = x_fold;
      y_d    = y_fold;
      z_d    = z_fold;
    end else if (state_q == S_ITER) begin
      cnt_d = last_step ? '0 : cnt_q + CW'(1);
      x_d   = x_rot;
      y_d   = y_rot;
      z_d   = z_rot;
    end

    // The result registers load only on the step that enters DONE.
    // They then stay stable for as long as the consumer stalls.
    if (last_step) begin
      x_out_d = (W + 2)'(x_rot >>> GUARD);
      y_out_d = (W + 2)'(y_rot >>> GUARD);
      z_out_d = z_rot;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      x_out_q <= '0;
      y_out_q <= '0;
      z_out_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      x_out_q <= x_out_d;
      y_out_q <= y_out_d;
      z_out_q <= z_out_d;
    end
  end

  assign x_out = x_out_q;
  assign y_out = y_out_q;
  assign z_out = z_out_q;

endmodule

// File: tb/tb_cordic_engine.sv
// ---------------------------------------------------------------------------
// tb_cordic_engine
//
// Stimulus pushes the expected result into a scoreboard queue.
// The expected result comes from a floating-point trigonometric model.
// A separate monitor pops and compares on every output handshake.
// It also checks output latency and result stability under backpressure.
// ---------------------------------------------------------------------------
module tb_cordic_engine;

  localparam int  W     = 16;
  localparam int  AW    = 16;
  localparam int  ITER  = 14;
  localparam int  GUARD = 4;
  localparam real ASCALE = 2.0 ** (AW - 3);
  localparam real AWRAP  = 2.0 ** AW;
  localparam real TOL    = 4.0;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic                 mode;
  logic signed [W-1:0]  x_in, y_in;
  logic signed [AW-1:0] z_in;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [W+1:0]  x_out, y_out;
  logic signed [AW-1:0] z_out;
  logic                 busy;

  always #5 clk = ~clk;

  cordic_engine #(
    .W    (W),
    .AW   (AW),
    .ITER (ITER),
    .GUARD(GUARD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .mode     (mode),
    .x_in     (x_in),
    .y_in     (y_in),
    .z_in     (z_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .x_out    (x_out),
    .y_out    (y_out),
    .z_out    (z_out),
    .busy     (busy)
  );

  typedef struct {
    int  id;
    bit  m;
    int  xi;
    int  yi;
    int  zi;
    real ex;
    real ey;
    real ez;
    int  acc_cyc;
  } item_t;

  item_t sb[$];
  int    n_cmp    = 0;
  int    n_err    = 0;
  int    cyc      = 0;
  int    next_id  = 0;
  int    rdy_mode = 0;   // 0 random, 1 force low, 2 force high
  real   kgain    = 1.0;

  always @(posedge clk) cyc <= cyc + 1;

  // -------------------------------------------------------------------------
  // Checks
  // -------------------------------------------------------------------------
  task automatic chk_eq(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_tol(input string nm, input real act, input real exp, input bit wrap);
    real e;
    e = act - exp;
    if (wrap) begin
      while (e > AWRAP / 2.0) e = e - AWRAP;
      while (e < -AWRAP / 2.0) e = e + AWRAP;
    end
    n_cmp++;
    if (e > TOL || e < -TOL) begin
      n_err++;
      $display("FAIL %s: got %0.1f, expected %0.2f (+/-%0.0f)", nm, act, exp, TOL);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model: ideal rotation or magnitude/atan2, scaled by the gain.
  // -------------------------------------------------------------------------
  function automatic item_t model(input bit m, input int xv, input int yv, input int zv);
    item_t it;
    real   xr, yr, th;
    xr    = xv;
    yr    = yv;
    it.m  = m;
    it.xi = xv;
    it.yi = yv;
    it.zi = zv;
    if (!m) begin
      th    = zv / ASCALE;
      it.ex = kgain * (xr * $cos(th) - yr * $sin(th));
      it.ey = kgain * (xr * $sin(th) + yr * $cos(th));
      it.ez = 0.0;
    end else begin
      it.ex = kgain * $sqrt(xr * xr + yr * yr);
      it.ey = 0.0;
      it.ez = zv + $atan2(yr, xr) * ASCALE;
    end
    it.id      = 0;
    it.acc_cyc = 0;
    return it;
  endfunction

  // -------------------------------------------------------------------------
  // Driver: present one transaction, wait for acceptance (bounded)
  // -------------------------------------------------------------------------
  task automatic send(input bit m, input int xv, input int yv, input int zv, output int waited);
    item_t it;
    bit    done;
    mode     = m;
    x_in     = W'(xv);
    y_in     = W'(yv);
    z_in     = AW'(zv);
    in_valid = 1'b1;
    waited   = 0;
    done     = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        it         = model(m, xv, yv, zv);
        it.id      = next_id;
        it.acc_cyc = cyc + 1;
        next_id++;
        sb.push_back(it);
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 300) begin
          n_cmp++;
          n_err++;
          $display("FAIL accept_timeout: in_ready low for %0d cycles, expected acceptance", waited);
          done = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb.size() > 0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    if (sb.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // -------------------------------------------------------------------------
  // out_ready driver (applied 2 time units after the edge)
  // -------------------------------------------------------------------------
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rdy_mode)
        0:       out_ready = ($urandom_range(0, 3) != 0);
        1:       out_ready = 1'b0;
        default: out_ready = 1'b1;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Monitor
  // -------------------------------------------------------------------------
  initial begin : monitor
    bit                   pv, phs;
    logic signed [W+1:0]  px, py;
    logic signed [AW-1:0] pz;
    item_t                it;
    pv  = 1'b0;
    phs = 1'b0;
    px  = '0;
    py  = '0;
    pz  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv  = 1'b0;
        phs = 1'b0;
      end else begin
        if (out_valid) begin
          if (!pv || phs) begin
            if (sb.size() == 0) begin
              n_cmp++;
              n_err++;
              $display("FAIL unexpected_output: out_valid with empty scoreboard, x=%0d y=%0d z=%0d",
                       x_out, y_out, z_out);
            end else begin
              chk_eq($sformatf("txn%0d_latency", sb[0].id), cyc - sb[0].acc_cyc, ITER);
            end
          end else begin
            chk_eq("hold_x", x_out, px);
            chk_eq("hold_y", y_out, py);
            chk_eq("hold_z", z_out, pz);
          end
          if (out_ready && sb.size() > 0) begin
            it = sb.pop_front();
            $display("txn %0d mode=%0d in=(%0d,%0d,%0d) out=(%0d,%0d,%0d) ref=(%0.1f,%0.1f,%0.1f)",
                     it.id, it.m, it.xi, it.yi, it.zi, x_out, y_out, z_out, it.ex, it.ey, it.ez);
            chk_tol($sformatf("txn%0d_x", it.id), real'(x_out), it.ex, 1'b0);
            chk_tol($sformatf("txn%0d_y", it.id), real'(y_out), it.ey, 1'b0);
            chk_tol($sformatf("txn%0d_z", it.id), real'(z_out), it.ez, 1'b1);
          end
        end
        pv  = out_valid;
        phs = out_valid && out_ready;
        px  = x_out;
        py  = y_out;
        pz  = z_out;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Main sequence
  // -------------------------------------------------------------------------
  int dm [11] = '{0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 1};
  int dx [11] = '{10000, 10000, 10000, -3000, -3000, 6000, 3000, -5000, -3000, 0, 5000};
  int dy [11] = '{0, 0, 0, 4000, -4000, -2000, 4000, 3000, 0, -5000, 0};
  int dz [11] = '{0, 12868, 25000, 0, 0, 12869, -12869, -25000, 0, 1000, -2000};

  initial begin : main
    int                   w, xv, yv, zv, t;
    bit                   m, seen;
    logic signed [W+1:0]  hx;

    for (int i = 0; i < ITER; i++) kgain = kgain * $sqrt(1.0 + $pow(2.0, -2.0 * i));

    rst      = 1'b1;
    in_valid = 1'b0;
    mode     = 1'b0;
    x_in     = '0;
    y_in     = '0;
    z_in     = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_eq("rst_out_valid", out_valid, 0);
    chk_eq("rst_in_ready", in_ready, 1);
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_x_out", x_out, 0);
    chk_eq("rst_z_out", z_out, 0);
    @(posedge clk);
    #1;

    // Directed vectors: nominal points, fold boundaries, axis cases.
    rdy_mode = 2;
    for (int i = 0; i < 11; i++) send(dm[i][0], dx[i], dy[i], dz[i], w);
    wait_drain();

    // Backpressure: result held for 5 cycles, then release it and accept
    // the next input on the same edge.
    rdy_mode = 1;
    send(1'b0, 5000, 1000, 7000, w);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!out_valid && t < 60);
    chk_eq("bp_out_valid_rise", out_valid, 1);
    hx = x_out;
    repeat (5) begin
      @(negedge clk);
      chk_eq("bp_out_valid_held", out_valid, 1);
      chk_eq("bp_in_ready_low", in_ready, 0);
      chk_eq("bp_x_out_held", x_out, hx);
    end
    @(posedge clk);
    #1;
    rdy_mode = 2;
    send(1'b1, 2000, -3000, 500, w);
    chk_eq("bp_same_edge_accept_wait", w, 0);
    wait_drain();

    // Reset in the middle of an iteration (cnt=5): nothing may come out.
    send(1'b0, 3000, 3000, 5000, w);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk_eq("midrst_out_valid", out_valid, 0);
    chk_eq("midrst_in_ready", in_ready, 1);
    chk_eq("midrst_busy", busy, 0);
    chk_eq("midrst_x_out", x_out, 0);
    chk_eq("midrst_y_out", y_out, 0);
    chk_eq("midrst_z_out", z_out, 0);
    seen = 1'b0;
    repeat (ITER + 6) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    chk_eq("midrst_no_stale_result", seen, 0);
    @(posedge clk);
    #1;

    // Random transactions with random input gaps and output backpressure.
    rdy_mode = 0;
    for (int n = 0; n < 60; n++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      m = 1'($urandom_range(0, 1));
      do begin
        xv = int'($urandom_range(0, 8000)) - 4000;
        yv = int'($urandom_range(0, 8000)) - 4000;
      end while (m && (xv * xv + yv * yv < 1000000));
      zv = int'($urandom_range(0, 51470)) - 25735;
      send(m, xv, yv, zv, w);
    end
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    n_err++;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
